// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, STATUS bit layout and the baud divisor.
// Used by both uart_rx_fifo and uart_tx.
package uart_pkg;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE  = 3'd0;
    localparam rx_state_t ST_START = 3'd1;
    localparam rx_state_t ST_DATA  = 3'd2;
    localparam rx_state_t ST_STOP  = 3'd3;
    localparam rx_state_t ST_BRK   = 3'd4;

    localparam int unsigned STAT_RDY  = 0;
    localparam int unsigned STAT_OVR  = 1;
    localparam int unsigned STAT_FERR = 2;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU-side and serial-side signals of the UART receiver.
// The device takes the slave modport; the host/bench drives through master.
interface uart_rx_fifo_if;

    logic       rx;
    logic       rd_n;
    logic       st_rd_n;
    logic [7:0] DOUT;
    logic [7:0] STATUS;
    logic       rdy;

    modport master (
        output rx,
        output rd_n,
        output st_rd_n,
        input  DOUT,
        input  STATUS,
        input  rdy
    );

    modport slave (
        input  rx,
        input  rd_n,
        input  st_rd_n,
        output DOUT,
        output STATUS,
        output rdy
    );

endinterface

// File: rtl/rx_fifo.sv
// Byte FIFO for received characters; head byte is shown combinationally, 8'hFF when empty.
// Pop on empty is ignored; push on full is accepted only if a pop happens in the same cycle.
module rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = empty ? 8'hFF : r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small FIFO, with IO-port style data and status reads.
// Strobes act on their synchronized rising edge so the CPU sees stable data for the whole read.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);

    localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);

    logic            r_rx_meta;
    logic            r_rx_sync;
    logic            r_rd_meta;
    logic            r_rd_sync;
    logic            r_rd_prev;
    logic            r_st_meta;
    logic            r_st_sync;
    logic            r_st_prev;
    logic [1:0]      r_flush;
    logic            r_armed;

    rx_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_ovr;
    logic            r_ferr;

    rx_state_t       w_state_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic [2:0]      w_bit_d;
    logic [7:0]      w_shift_d;
    logic            w_push;
    logic            w_ferr_set;
    logic            w_ovr_set;
    logic            w_rd_rise;
    logic            w_st_rise;
    logic            w_full;
    logic            w_empty;
    logic [7:0]      w_dout;
    logic [7:0]      w_status;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rd_meta <= 1'b1;
            r_rd_sync <= 1'b1;
            r_rd_prev <= 1'b1;
            r_st_meta <= 1'b1;
            r_st_sync <= 1'b1;
            r_st_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_sync <= r_rx_meta;
            r_rd_meta <= bus.rd_n;
            r_rd_sync <= r_rd_meta;
            r_rd_prev <= r_rd_sync;
            r_st_meta <= bus.st_rd_n;
            r_st_sync <= r_st_meta;
            r_st_prev <= r_st_sync;
        end
    end

    // After reset the synchronizer holds its reset value for two cycles; only a real
    // high level on rx arms the receiver, so a frame cut by reset is not picked up mid-way.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_flush <= {r_flush[0], 1'b1};
            if (r_flush[1] && r_rx_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_rd_rise = r_rd_sync & ~r_rd_prev;
    assign w_st_rise = r_st_sync & ~r_st_prev;

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_bit_d    = r_bit;
        w_shift_d  = r_shift;
        w_push     = 1'b0;
        w_ferr_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed && !r_rx_sync) begin
                    w_state_d = ST_START;
                    w_cnt_d   = '0;
                end
            end
            ST_START: begin
                if (r_cnt == CNT_W'(HALF - 1)) begin
                    w_cnt_d   = '0;
                    w_bit_d   = '0;
                    w_state_d = r_rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == CNT_W'(DIV - 1)) begin
                    w_cnt_d   = '0;
                    w_shift_d = {r_rx_sync, r_shift[7:1]};
                    w_bit_d   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_d = ST_STOP;
                    end
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (r_cnt == CNT_W'(DIV - 1)) begin
                    w_cnt_d = '0;
                    if (r_rx_sync) begin
                        w_push    = 1'b1;
                        w_state_d = ST_IDLE;
                    end else begin
                        w_ferr_set = 1'b1;
                        w_state_d  = ST_BRK;
                    end
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            ST_BRK: begin
                if (r_rx_sync) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
        end
    end

    // A pop in the same cycle makes room, so a push into a full FIFO is then not an overrun.
    assign w_ovr_set = w_push & w_full & ~w_rd_rise;

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovr  <= (r_ovr & ~w_st_rise) | w_ovr_set;
            r_ferr <= (r_ferr & ~w_st_rise) | w_ferr_set;
        end
    end

    rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_rd_rise),
        .din   (r_shift),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_status            = 8'h00;
        w_status[STAT_RDY]  = ~w_empty;
        w_status[STAT_OVR]  = r_ovr;
        w_status[STAT_FERR] = r_ferr;
    end

    assign bus.DOUT   = w_dout;
    assign bus.STATUS = w_status;
    assign bus.rdy    = ~w_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at 50 MHz / 115200 baud (434 clocks per bit).
// Stimulus queues the expected bytes/status; monitors check them at each CPU read strobe.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DIV = 434;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] exp_data [$];
    logic [7:0] exp_stat [$];

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(
        .CLK_HZ (50000000),
        .BAUD   (115200),
        .DEPTH  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rx = f[i];
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic do_read();
        @(negedge clk);
        bus.rd_n = 1'b0;
        repeat (4) @(negedge clk);
        bus.rd_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_status(input logic [7:0] e);
        exp_stat.push_back(e);
        @(negedge clk);
        bus.st_rd_n = 1'b0;
        repeat (4) @(negedge clk);
        bus.st_rd_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Data port monitor: DOUT must hold the next expected byte while rd_n is low.
    initial begin : data_mon
        logic [7:0] e;
        logic       er;
        forever begin
            @(negedge bus.rd_n);
            #1;
            if (exp_data.size() == 0) begin
                e  = 8'hFF;
                er = 1'b0;
            end else begin
                e  = exp_data.pop_front();
                er = 1'b1;
            end
            chk("read_dout", bus.DOUT, e);
            chk("read_rdy", {7'b0, bus.rdy}, {7'b0, er});
        end
    end

    initial begin : stat_mon
        logic [7:0] e;
        forever begin
            @(negedge bus.st_rd_n);
            #1;
            e = (exp_stat.size() == 0) ? 8'h00 : exp_stat.pop_front();
            chk("read_status", bus.STATUS, e);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: cycle limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [9:0] f;
        logic       found;

        rst        = 1'b0;
        bus.rx     = 1'b1;
        bus.rd_n   = 1'b1;
        bus.st_rd_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_dout", bus.DOUT, 8'hFF);
        chk("reset_rdy", {7'b0, bus.rdy}, 8'h00);
        chk("reset_status", bus.STATUS, 8'h00);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Single byte, then read it out.
        exp_data.push_back(8'h55);
        send_byte(8'h55);
        chk("rx55_dout", bus.DOUT, 8'h55);
        chk("rx55_rdy", {7'b0, bus.rdy}, 8'h01);
        do_read();
        chk("pop55_dout", bus.DOUT, 8'hFF);
        chk("pop55_rdy", {7'b0, bus.rdy}, 8'h00);

        // Glitch on rx shorter than half a bit: rejected.
        bus.rx = 1'b0;
        repeat (100) @(negedge clk);
        bus.rx = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_state", {5'b0, dut.r_state}, {5'b0, ST_IDLE});
        chk("glitch_status", bus.STATUS, 8'h00);
        do_read();

        // Five bytes into four entries: fifth dropped, overrun set.
        for (int i = 1; i <= 4; i++) exp_data.push_back(8'(i));
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        chk("ovr_status", bus.STATUS, 8'h03);
        do_status(8'h03);

        // Full FIFO: pop edge lands on the cycle 0x77 is pushed.
        exp_data.push_back(8'h77);
        @(negedge clk);
        bus.rd_n = 1'b0;
        repeat (10) @(negedge clk);
        fork
            send_byte(8'h77);
            begin
                found = 1'b0;
                for (int k = 0; k < 6000; k++) begin
                    @(negedge clk);
                    if (dut.r_state == ST_STOP && int'(dut.r_cnt) == DIV - 3) begin
                        found = 1'b1;
                        break;
                    end
                end
                bus.rd_n = 1'b1;
                chk("coincide_found", {7'b0, found}, 8'h01);
            end
        join
        chk("coincide_count", 8'(dut.u_fifo.r_count), 8'h04);
        chk("coincide_status", bus.STATUS, 8'h01);
        repeat (4) do_read();
        do_status(8'h00);

        // Frame error: stop bit low for two bit times.
        f = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 9; i++) begin
            bus.rx = f[i];
            repeat (DIV) @(negedge clk);
        end
        bus.rx = 1'b0;
        repeat (DIV) @(negedge clk);
        chk("ferr_state_brk", {5'b0, dut.r_state}, {5'b0, ST_BRK});
        repeat (DIV) @(negedge clk);
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("ferr_state_idle", {5'b0, dut.r_state}, {5'b0, ST_IDLE});
        do_status(8'h04);
        exp_data.push_back(8'h3C);
        send_byte(8'h3C);
        chk("rx3c_status", bus.STATUS, 8'h01);

        // Reset inside the data bits of 0xC3 while 0x3C is still queued.
        bus.rx = 1'b0;
        repeat (DIV) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        bus.rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_dout", bus.DOUT, 8'hFF);
        chk("midrst_rdy", {7'b0, bus.rdy}, 8'h00);
        chk("midrst_status", bus.STATUS, 8'h00);
        chk("midrst_state", {5'b0, dut.r_state}, {5'b0, ST_IDLE});
        exp_data.delete();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (4 * DIV - DIV / 4 - 5) @(negedge clk);
        bus.rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        chk("postrst_state", {5'b0, dut.r_state}, {5'b0, ST_IDLE});
        chk("postrst_rdy", {7'b0, bus.rdy}, 8'h00);
        exp_data.push_back(8'hC3);
        send_byte(8'hC3);
        do_read();
        do_status(8'h00);

        repeat (20) @(negedge clk);
        chk("leftover_expected", 8'(exp_data.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
